// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared half-precision definitions for the floating-point adder datapath.
//   EXP_WIDTH / MAN_WIDTH : IEEE-754 binary16 exponent and fraction widths
//   fp_unpacked_t         : {sign, effective exponent, mantissa with hidden bit}
//   unpack_fp()           : splits a packed operand into fp_unpacked_t
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_WIDTH = 5;
    localparam int MAN_WIDTH = 10;
    localparam int FP_WIDTH  = 1 + EXP_WIDTH + MAN_WIDTH;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [MAN_WIDTH:0]   man;
    } fp_unpacked_t;

    // Subnormals (exp field 0) have no hidden bit and behave as exponent 1,
    // which keeps them on the same scale as the smallest normal number.
    function automatic fp_unpacked_t unpack_fp(input logic [FP_WIDTH-1:0] op);
        fp_unpacked_t         r;
        logic [EXP_WIDTH-1:0] e;
        logic                 hidden;
        e      = op[FP_WIDTH-2 -: EXP_WIDTH];
        hidden = |e;
        r.sign = op[FP_WIDTH-1];
        r.exp  = hidden ? e : EXP_WIDTH'(1);
        r.man  = {hidden, op[MAN_WIDTH-1:0]};
        return r;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// ---------------------------------------------------------------------------
// fp_unpack
// Combinational unpack of one half-precision operand.
//   op      : packed operand {sign, exp, fraction}
//   unp     : sign, effective exponent, mantissa with hidden bit
//   special : exponent field all ones (Inf or NaN)
// ---------------------------------------------------------------------------
module fp_unpack
    import fp_pkg::*;
(
    input  logic [FP_WIDTH-1:0] op,
    output fp_unpacked_t        unp,
    output logic                special
);

    assign unp     = unpack_fp(op);
    assign special = &op[FP_WIDTH-2 -: EXP_WIDTH];

endmodule

// File: rtl/fp_align_stage.sv
// ---------------------------------------------------------------------------
// fp_align_stage
// Two-stage pre-alignment stage of the floating-point adder. Orders the two
// operands by magnitude and produces everything the downstream barrel shifter
// needs to right-shift the smaller mantissa into alignment.
//
// Stage 1 unpacks and compares; stage 2 saturates the shift amount and drives
// the outputs. Valid/ready on both sides, one pair per cycle, latency 2.
//
// Ports:
//   clock_in, reset_in          clock, synchronous active-high reset
//   valid_in, ready_out         upstream handshake
//   op_a_in, op_b_in, sub_in    operands and add/subtract select
//   valid_out, ready_in         downstream handshake
//   large_man_out               larger-magnitude extended mantissa
//   small_man_out               smaller-magnitude extended mantissa (unshifted)
//   amount_out, shift_dir_out   shifter amount (saturated) and direction
//   exp_out, sign_out           exponent of the larger operand, result sign
//   eff_sub_out, swap_out       effective subtraction, B was larger
//   special_out                 an operand is Inf/NaN
//   sticky_out                  OR of small-mantissa bits lost by the shift
//
// Build option: define FP_ALIGN_STICKY_EN to compute sticky_out; otherwise it
// is tied low and no mask logic exists.
// ---------------------------------------------------------------------------
module fp_align_stage #(
    parameter int EXP_WIDTH    = fp_pkg::EXP_WIDTH,
    parameter int MAN_WIDTH    = fp_pkg::MAN_WIDTH,
    parameter int GUARD_BITS   = 5,
    parameter int AMOUNT_WIDTH = 8,
    localparam int MW          = MAN_WIDTH + 1 + GUARD_BITS
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    input  logic [EXP_WIDTH+MAN_WIDTH:0] op_a_in,
    input  logic [EXP_WIDTH+MAN_WIDTH:0] op_b_in,
    input  logic                        sub_in,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [MW-1:0]               large_man_out,
    output logic [MW-1:0]               small_man_out,
    output logic [AMOUNT_WIDTH-1:0]     amount_out,
    output logic                        shift_dir_out,
    output logic [EXP_WIDTH-1:0]        exp_out,
    output logic                        sign_out,
    output logic                        eff_sub_out,
    output logic                        swap_out,
    output logic                        special_out,
    output logic                        sticky_out
);

    import fp_pkg::*;

    localparam int DW = EXP_WIDTH + 1;

    fp_unpacked_t unp_a;
    fp_unpacked_t unp_b;
    logic         special_a;
    logic         special_b;

    fp_unpack u_unpack_a (.op(op_a_in), .unp(unp_a), .special(special_a));
    fp_unpack u_unpack_b (.op(op_b_in), .unp(unp_b), .special(special_b));

    // Stage 1 combinational compare
    logic                 swap_next;
    logic [MW-1:0]        ext_a;
    logic [MW-1:0]        ext_b;
    logic [EXP_WIDTH-1:0] exp_large_next;
    logic [EXP_WIDTH-1:0] exp_small_next;
    logic [DW-1:0]        diff_next;

    // Exponent sits above mantissa, so one unsigned compare orders magnitude.
    // A strict greater-than lets A win ties.
    assign swap_next      = {unp_b.exp, unp_b.man} > {unp_a.exp, unp_a.man};
    assign ext_a          = {unp_a.man, {GUARD_BITS{1'b0}}};
    assign ext_b          = {unp_b.man, {GUARD_BITS{1'b0}}};
    assign exp_large_next = swap_next ? unp_b.exp : unp_a.exp;
    assign exp_small_next = swap_next ? unp_a.exp : unp_b.exp;
    assign diff_next      = {1'b0, exp_large_next} - {1'b0, exp_small_next};

    // Pipeline registers
    logic                 s1_valid;
    logic [MW-1:0]        s1_large_man;
    logic [MW-1:0]        s1_small_man;
    logic [EXP_WIDTH-1:0] s1_exp;
    logic [DW-1:0]        s1_diff;
    logic                 s1_sign;
    logic                 s1_eff_sub;
    logic                 s1_swap;
    logic                 s1_special;

    logic                    s2_valid;
    logic [MW-1:0]           s2_large_man;
    logic [MW-1:0]           s2_small_man;
    logic [AMOUNT_WIDTH-1:0] s2_amount;
    logic [EXP_WIDTH-1:0]    s2_exp;
    logic                    s2_sign;
    logic                    s2_eff_sub;
    logic                    s2_swap;
    logic                    s2_special;

    logic s2_ready;

    // A stage may load when it is empty or its contents leave this cycle.
    assign s2_ready  = !s2_valid || ready_in;
    assign ready_out = !s1_valid || s2_ready;

    // Stage 1: capture the ordered operand pair on an input transfer
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            s1_valid     <= 1'b0;
            s1_large_man <= '0;
            s1_small_man <= '0;
            s1_exp       <= '0;
            s1_diff      <= '0;
            s1_sign      <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_swap      <= 1'b0;
            s1_special   <= 1'b0;
        end else if (ready_out) begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_large_man <= swap_next ? ext_b : ext_a;
                s1_small_man <= swap_next ? ext_a : ext_b;
                s1_exp       <= exp_large_next;
                s1_diff      <= diff_next;
                s1_sign      <= swap_next ? (unp_b.sign ^ sub_in) : unp_a.sign;
                s1_eff_sub   <= unp_a.sign ^ unp_b.sign ^ sub_in;
                s1_swap      <= swap_next;
                s1_special   <= special_a || special_b;
            end
        end
    end

    // Shift amount, saturated only when the amount port is narrower than diff
    logic [AMOUNT_WIDTH-1:0] amount_next;

    generate
        if (AMOUNT_WIDTH >= DW) begin : g_amount_wide
            assign amount_next = AMOUNT_WIDTH'(s1_diff);
        end else begin : g_amount_sat
            assign amount_next = (s1_diff > DW'({AMOUNT_WIDTH{1'b1}})) ?
                                 {AMOUNT_WIDTH{1'b1}} : s1_diff[AMOUNT_WIDTH-1:0];
        end
    endgenerate

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            s2_valid     <= 1'b0;
            s2_large_man <= '0;
            s2_small_man <= '0;
            s2_amount    <= '0;
            s2_exp       <= '0;
            s2_sign      <= 1'b0;
            s2_eff_sub   <= 1'b0;
            s2_swap      <= 1'b0;
            s2_special   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_large_man <= s1_large_man;
                s2_small_man <= s1_small_man;
                s2_amount    <= amount_next;
                s2_exp       <= s1_exp;
                s2_sign      <= s1_sign;
                s2_eff_sub   <= s1_eff_sub;
                s2_swap      <= s1_swap;
                s2_special   <= s1_special;
            end
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    logic [MW-1:0] sticky_mask;
    logic          s2_sticky;

    // Mask selects the bits the right shift pushes out; at MW or beyond the
    // whole mantissa is lost.
    always_comb begin
        sticky_mask = '1;
        if (32'(amount_next) < MW) begin
            sticky_mask = (MW'(1) << amount_next) - MW'(1);
        end
    end

    // Sticky register follows the same load rule as the rest of stage 2
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            s2_sticky <= 1'b0;
        end else if (s2_ready && s1_valid) begin
            s2_sticky <= |(s1_small_man & sticky_mask);
        end
    end

    assign sticky_out = s2_sticky;
`else
    assign sticky_out = 1'b0;
`endif

    assign valid_out     = s2_valid;
    assign shift_dir_out = s2_valid;
    assign large_man_out = s2_large_man;
    assign small_man_out = s2_small_man;
    assign amount_out    = s2_amount;
    assign exp_out       = s2_exp;
    assign sign_out      = s2_sign;
    assign eff_sub_out   = s2_eff_sub;
    assign swap_out      = s2_swap;
    assign special_out   = s2_special;

endmodule

// File: tb/tb_fp_align_stage.sv
// ---------------------------------------------------------------------------
// tb_fp_align_stage
// Directed self-checking bench for fp_align_stage (half-precision defaults).
// Honours FP_ALIGN_STICKY_EN for the expected sticky values.
// ---------------------------------------------------------------------------
module tb_fp_align_stage;

`ifdef FP_ALIGN_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        sub = 1'b0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [15:0] large_man;
    logic [15:0] small_man;
    logic [7:0]  amount;
    logic        shift_dir;
    logic [4:0]  exp_o;
    logic        sign_o;
    logic        eff_sub;
    logic        swap;
    logic        special;
    logic        sticky;

    int n_checks = 0;
    int n_fail   = 0;

    fp_align_stage dut (
        .clock_in      (clock),
        .reset_in      (reset),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .op_a_in       (op_a),
        .op_b_in       (op_b),
        .sub_in        (sub),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .large_man_out (large_man),
        .small_man_out (small_man),
        .amount_out    (amount),
        .shift_dir_out (shift_dir),
        .exp_out       (exp_o),
        .sign_out      (sign_o),
        .eff_sub_out   (eff_sub),
        .swap_out      (swap),
        .special_out   (special),
        .sticky_out    (sticky)
    );

    always #5 clock = ~clock;

    // Hard stop in case a wait never completes
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, observed running, expected done");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one pair for a single cycle, return at the negedge where it is on the outputs
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s);
        op_a     = a;
        op_b     = b;
        sub      = s;
        valid_in = 1'b1;
        @(negedge clock);
        valid_in = 1'b0;
        @(negedge clock);
    endtask

    task automatic checkOutput(input string tag,
                               input logic [15:0] e_large, input logic [15:0] e_small,
                               input logic [7:0] e_amount, input logic [4:0] e_exp,
                               input logic e_sign, input logic e_eff, input logic e_swap,
                               input logic e_special, input logic e_sticky);
        check({tag, ".valid"},     64'(valid_out), 64'(1));
        check({tag, ".shift_dir"}, 64'(shift_dir), 64'(1));
        check({tag, ".large_man"}, 64'(large_man), 64'(e_large));
        check({tag, ".small_man"}, 64'(small_man), 64'(e_small));
        check({tag, ".amount"},    64'(amount),    64'(e_amount));
        check({tag, ".exp"},       64'(exp_o),     64'(e_exp));
        check({tag, ".sign"},      64'(sign_o),    64'(e_sign));
        check({tag, ".eff_sub"},   64'(eff_sub),   64'(e_eff));
        check({tag, ".swap"},      64'(swap),      64'(e_swap));
        check({tag, ".special"},   64'(special),   64'(e_special));
        check({tag, ".sticky"},    64'(sticky),    64'(e_sticky));
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({large_man, small_man, amount, exp_o, sign_o, eff_sub, swap, special, sticky, shift_dir});
    endfunction

    initial begin
        int          sent;
        int          recv;
        logic        prev_stall;
        logic [16:0] held;
        logic        exp_ready;

        $display("[TB] start");
        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("reset.valid_out", 64'(valid_out), 64'(0));
        check("reset.data",      all_outputs(),  64'(0));
        reset = 1'b0;
        @(negedge clock);
        check("reset.ready_out", 64'(ready_out), 64'(1));

        // 1.0 + 0.5
        applyStimulus(16'h3C00, 16'h3800, 1'b0);
        checkOutput("vec1", 16'h8000, 16'h8000, 8'd1, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0.5 + (-1.0): B larger, effective subtraction
        applyStimulus(16'h3800, 16'hBC00, 1'b0);
        checkOutput("vec2", 16'h8000, 16'h8000, 8'd1, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Min subnormal vs max normal: shift 29 discards the whole small mantissa
        applyStimulus(16'h0001, 16'h7BFF, 1'b0);
        checkOutput("vec3", 16'hFFE0, 16'h0020, 8'd29, 5'd30, 1'b0, 1'b0, 1'b1, 1'b0, STICKY_ON);

        // +Inf + 1.0
        applyStimulus(16'h7C00, 16'h3C00, 1'b0);
        checkOutput("vec4", 16'h8000, 16'h8000, 8'd16, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, STICKY_ON);

        // A - A with subtract: tie keeps A as large, sign is A's
        applyStimulus(16'h4500, 16'h4500, 1'b1);
        checkOutput("vec5_tie", 16'hA000, 16'hA000, 8'd0, 5'd17, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clock);
        check("idle.valid_out", 64'(valid_out), 64'(0));
        check("idle.shift_dir", 64'(shift_dir), 64'(0));

        // Streaming: 10 pairs, consumer stalled during cycles 3-5
        sent       = 0;
        recv       = 0;
        prev_stall = 1'b0;
        held       = '0;
        for (int c = 0; c < 60 && recv < 10; c++) begin
            if (valid_out) begin
                check("stream.large_man", 64'(large_man), 64'(16'h8000 + 16'(recv * 32)));
            end
            if (prev_stall) begin
                check("stream.stall_hold", 64'({valid_out, large_man}), 64'(held));
            end
            ready_in = !(c >= 3 && c <= 5);
            valid_in = (sent < 10);
            op_a     = 16'h3C00 + 16'(sent);
            op_b     = 16'h3800;
            sub      = 1'b0;
            #1;
            exp_ready = !((sent - recv) == 2 && !ready_in);
            check("stream.ready_out", 64'(ready_out), 64'(exp_ready));
            if (valid_in && ready_out) sent++;
            if (valid_out && ready_in) recv++;
            prev_stall = valid_out && !ready_in;
            held       = {valid_out, large_man};
            @(negedge clock);
        end
        valid_in = 1'b0;
        check("stream.sent", 64'(sent), 64'(10));
        check("stream.recv", 64'(recv), 64'(10));
        check("stream.drained", 64'(valid_out), 64'(0));

        // Fill both stages with the consumer stalled, then reset
        ready_in = 1'b0;
        op_a     = 16'h3C00;
        op_b     = 16'h3800;
        valid_in = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("full.valid_out", 64'(valid_out), 64'(1));
        check("full.ready_out", 64'(ready_out), 64'(0));
        reset    = 1'b1;
        valid_in = 1'b0;
        @(negedge clock);
        check("flush.valid_out", 64'(valid_out), 64'(0));
        check("flush.data",      all_outputs(),  64'(0));
        reset    = 1'b0;
        ready_in = 1'b1;
        @(negedge clock);
        check("flush.ready_out", 64'(ready_out), 64'(1));
        @(negedge clock);
        check("flush.no_ghost", 64'(valid_out), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
